// File: rtl/ps2_host_tx_if.sv
// +------------------------------------------------------------------------+
// | ps2_host_tx_if                                                          |
// | Command-byte handshake plus PS/2 pin levels and open-drain enables.     |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  modport master (
    output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    input  tx_ready, tx_done, tx_error, ps2_clk_oe, ps2_data_oe
  );

  modport slave (
    input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    output tx_ready, tx_done, tx_error, ps2_clk_oe, ps2_data_oe
  );
endinterface

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// +------------------------------------------------------------------------+
// | ps2_host_tx                                                             |
// | PS/2 host-to-device command transmitter with inhibit, ack and timeout.  |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic          clk,
  input  logic          reset_n,
  ps2_host_tx_if.slave  bus
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_START     = 3'd2,
    S_SHIFT     = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       shift_q, shift_d;
  logic [3:0]       idx_q, idx_d;
  logic             drive_q, drive_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;
  logic fall_w;
  logic timeout_w;

  // Synchronizers idle high so reset never fabricates a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= bus.ps2_clk_in;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= bus.ps2_data_in;
      data_sync_q <= data_meta_q;
    end
  end

  assign fall_w    = clk_prev_q & ~clk_sync_q;
  assign timeout_w = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      idx_q     <= '0;
      drive_q   <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      drive_q   <= drive_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    drive_d = drive_q;
    done_d  = 1'b0;
    error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.tx_valid) begin
          shift_d = {1'b1, ~^bus.tx_data, bus.tx_data};
          cnt_d   = CNT_W'(INHIBIT_CYCLES);
          state_d = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_START;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_START: begin
        state_d = S_SHIFT;
        idx_d   = 4'd0;
        cnt_d   = '0;
        drive_d = 1'b1;
      end

      // Each device falling edge puts the next LSB-first bit on the line.
      S_SHIFT: begin
        if (fall_w) begin
          drive_d = ~shift_q[0];
          shift_d = {1'b0, shift_q[9:1]};
          cnt_d   = '0;
          if (idx_q == 4'd9) begin
            state_d = S_ACK;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else if (timeout_w) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_ACK: begin
        if (fall_w) begin
          cnt_d = '0;
          if (!data_sync_q) begin
            state_d = S_WAIT_IDLE;
          end else begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end else if (timeout_w) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT_IDLE: begin
        if (clk_sync_q && data_sync_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (timeout_w) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Line enables are decoded from the next state so they are glitch-free flops.
    clk_oe_d  = (state_d == S_INHIBIT) || (state_d == S_START);
    data_oe_d = (state_d == S_START) || ((state_d == S_SHIFT) && drive_d);
  end

  assign bus.tx_ready    = (state_q == S_IDLE);
  assign bus.tx_done     = done_q;
  assign bus.tx_error    = error_q;
  assign bus.ps2_clk_oe  = clk_oe_q;
  assign bus.ps2_data_oe = data_oe_q;

endmodule

`default_nettype wire
